isi_match_pipe: RTL and testbench
=================================

Name: isi_match_pipe

Overview:
- Parametrised, pipelined successor to the single-pair ISI equality check in LandscapeSampling.
- Each input beat carries one reference ISI (isi_x). It is compared against N_CH candidate ISIs in parallel, either for exact equality or within a programmable tolerance.
- Output per beat: a match mask, the lowest matching index, a match count, and a forwarded isi_z.
- Valid/ready handshake on both sides, plus a saturating hit statistic. Sits between the address/ISI extraction stage and Mux_acc.

Parameters:
- BIT_ISI, 8, width of each ISI value.
- N_CH, 4, number of candidate channels (>=1).
- BIT_TOL, 4, width of the tolerance input.
- IDX_W, clog2(N_CH) (min 1), width of match_idx.
- CNT_W, clog2(N_CH+1), width of match_cnt.
- STAT_W, 16, width of the hit_total counter.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- isi_x  in  BIT_ISI  reference ISI.
- comp_addr_x  in  1  reference is a comparator address word (never matches).
- isi_y  in  N_CH*BIT_ISI  candidate ISIs; channel i at [i*BIT_ISI +: BIT_ISI].
- comp_addr_y  in  N_CH  per-channel comparator-address flag.
- tol  in  BIT_TOL  tolerance, sampled with each accepted beat.
- tol_en  in  1  1 = tolerance mode, 0 = exact mode; sampled with each beat.
- clear_stats  in  1  synchronous clear of hit_total.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- isi_z  out  BIT_ISI  isi_x of the beat.
- match  out  1  OR of match_mask.
- match_mask  out  N_CH  per-channel match.
- match_idx  out  IDX_W  lowest set bit of match_mask; 0 when no match.
- match_cnt  out  CNT_W  popcount of match_mask.
- hit_total  out  STAT_W  count of delivered results with match=1; saturating.

Behaviour:
- Reset (clr_n=0, async): all pipeline valids and all registered outputs go to 0, including hit_total. in_ready=1 from the first cycle after reset is released.
- Pipeline structure: two register stages, S1 (compare) and S2 (reduce/output). Latency is 2 cycles from accepted beat to out_valid when not stalled. Sustains 1 beat/cycle when out_ready=1.
- Flow control:
  - s2_adv = !out_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv (combinational, no input-to-output combinational path other than this)
  - A beat is accepted when in_valid & in_ready.
- Hold rule: while out_valid & !out_ready, every output holds stable and S1 holds its content.
- Compare stage (S1): for each channel i, the unsigned diff |isi_x - isi_y[i]| is formed at BIT_ISI+1 bits with no wrap-around. thr = tol_en ? zero-extended tol : 0. mask[i] = 1 iff all of:
  - diff <= thr
  - !comp_addr_x
  - !comp_addr_y[i]
  - isi_x != 0
- isi_x=0 never matches but is still forwarded to isi_z.
- Reduce stage (S2): computes match, match_idx (priority to lowest index) and match_cnt from the S1 mask, and registers isi_z.
- Statistics on a handshake (out_valid & out_ready & match):
  - hit_total increments, saturating at all-ones (no wrap).
  - If clear_stats is asserted in the same cycle, clear wins and hit_total=0.
- Bubbles: when no valid beat is present, the data outputs hold their last values and out_valid=0.
- Async reset mid-stream discards all in-flight beats; nothing is delivered after reset release until new beats are accepted.
- With N_CH=1, IDX_W=1 and match_idx is always 0.

Test Plan:
- Exact mode, N_CH=4, isi_x=0x25, isi_y={0x25,0x10,0x25,0x24}, all flags 0, out_ready=1 -> 2 cycles later: out_valid=1, match_mask=0101, match_idx=0, match_cnt=2, isi_z=0x25, hit_total=1.
- Tolerance mode, tol=2, isi_x=0x02, isi_y ch0=0xFF, ch1=0x04, ch2=0x00, ch3=0x05 -> mask=0110 (0xFF is no match; no wrap-around), match_idx=1, match_cnt=2.
- Gating: same beat with comp_addr_y=0010, then with comp_addr_x=1, then with isi_x=0 and all isi_y=0 -> mask=0100, then 0000, then 0000; isi_z=0 is forwarded on the last beat.
- Backpressure: stream 5 beats with in_valid=1 and out_ready low for cycles 3-6 -> in_ready drops once S1 and S2 are full; outputs are stable while stalled; all 5 results are delivered in order with none lost or duplicated.
- Statistics: STAT_W=2, 5 matching handshakes -> hit_total reads 1, 2, 3, 3, 3. Then assert clear_stats together with a matching handshake -> hit_total=0.
- Reset: drive clr_n low for 1 cycle while 2 beats are in flight -> out_valid=0 and hit_total=0 immediately (async); in_ready=1 after release; no stale result ever appears.

Source files
------------

// File: rtl/isi_match_pipe.sv
// isi_match_pipe: compares one reference ISI per beat against N_CH candidate
// ISIs. Each beat can use exact or tolerance matching. The block has two
// register stages: S1 holds the compare result and S2 holds the reduced result
// on the outputs. Both sides use a valid/ready handshake. hit_total counts the
// delivered results that matched and saturates at all-ones.
module isi_match_pipe #(
    parameter int BIT_ISI = 8,
    parameter int N_CH    = 4,
    parameter int BIT_TOL = 4,
    parameter int IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int CNT_W   = $clog2(N_CH + 1),
    parameter int STAT_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    clr_n_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [BIT_ISI-1:0]      isi_x_i,
    input  logic                    comp_addr_x_i,
    input  logic [N_CH*BIT_ISI-1:0] isi_y_i,
    input  logic [N_CH-1:0]         comp_addr_y_i,
    input  logic [BIT_TOL-1:0]      tol_i,
    input  logic                    tol_en_i,
    input  logic                    clear_stats_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [BIT_ISI-1:0]      isi_z_o,
    output logic                    match_o,
    output logic [N_CH-1:0]         match_mask_o,
    output logic [IDX_W-1:0]        match_idx_o,
    output logic [CNT_W-1:0]        match_cnt_o,
    output logic [STAT_W-1:0]       hit_total_o
);

    // The compare width covers the full unsigned distance with no wrap-around,
    // and it also covers a tolerance that is wider than the ISI.
    localparam int DIFF_W = BIT_ISI + 1;
    localparam int CMP_W  = (BIT_TOL > DIFF_W) ? BIT_TOL : DIFF_W;

    function automatic logic [CMP_W-1:0] abs_diff(input logic [BIT_ISI-1:0] a,
                                                  input logic [BIT_ISI-1:0] b);
        if (a >= b) return CMP_W'(a) - CMP_W'(b);
        else        return CMP_W'(b) - CMP_W'(a);
    endfunction

    logic                s1_valid_q, s1_valid_d;
    logic [N_CH-1:0]     s1_mask_q;
    logic [BIT_ISI-1:0]  s1_isi_q;

    logic                out_valid_q, out_valid_d;
    logic [N_CH-1:0]     mask_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                match_q;
    logic [BIT_ISI-1:0]  isi_z_q;
    logic [STAT_W-1:0]   hit_q, hit_d;

    logic                s1_adv, s2_adv, accept, s2_load, handshake;
    logic [CMP_W-1:0]    thr_c;
    logic [N_CH-1:0]     mask_c;
    logic [IDX_W-1:0]    idx_c;
    logic [CNT_W-1:0]    cnt_c;

    // Flow control: each stage advances when it is empty or when the stage
    // after it advances.
    always_comb begin
        s2_adv    = !out_valid_q || out_ready_i;
        s1_adv    = !s1_valid_q || s2_adv;
        accept    = in_valid_i && s1_adv;
        s2_load   = s2_adv && s1_valid_q;
        handshake = out_valid_q && out_ready_i;
    end

    assign in_ready_o = s1_adv;

    // Per-channel compare. A zero reference never matches. A comparator
    // address word on either side never matches.
    always_comb begin
        thr_c  = tol_en_i ? CMP_W'(tol_i) : '0;
        mask_c = '0;
        for (int i = 0; i < N_CH; i++) begin
            mask_c[i] = (abs_diff(isi_x_i, isi_y_i[i*BIT_ISI +: BIT_ISI]) <= thr_c)
                        && !comp_addr_x_i && !comp_addr_y_i[i]
                        && (isi_x_i != '0);
        end
    end

    // Reduction of the S1 mask. The loop scans downwards, so the lowest set
    // index is the one that remains.
    always_comb begin
        idx_c = '0;
        cnt_c = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (s1_mask_q[i]) idx_c = IDX_W'(i);
        end
        for (int i = 0; i < N_CH; i++) begin
            cnt_c = cnt_c + CNT_W'(s1_mask_q[i]);
        end
    end

    // Next-state values for the valids and for the saturating hit counter.
    // A clear takes priority over a hit in the same cycle.
    always_comb begin
        s1_valid_d  = s1_adv ? accept : s1_valid_q;
        out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
        hit_d       = hit_q;
        if (clear_stats_i)
            hit_d = '0;
        else if (handshake && match_q && !(&hit_q))
            hit_d = hit_q + STAT_W'(1);
    end

    // Pipeline valids and the statistic.
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            hit_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            hit_q       <= hit_d;
        end
    end

    // S1 data loads only on an accepted beat, so it holds through bubbles
    // and stalls.
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            s1_mask_q <= '0;
            s1_isi_q  <= '0;
        end else if (accept) begin
            s1_mask_q <= mask_c;
            s1_isi_q  <= isi_x_i;
        end
    end

    // S2 data loads only when a valid S1 beat moves forward. Otherwise the
    // outputs keep their last values.
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            mask_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            isi_z_q <= '0;
        end else if (s2_load) begin
            mask_q  <= s1_mask_q;
            idx_q   <= idx_c;
            cnt_q   <= cnt_c;
            match_q <= |s1_mask_q;
            isi_z_q <= s1_isi_q;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign isi_z_o      = isi_z_q;
    assign match_o      = match_q;
    assign match_mask_o = mask_q;
    assign match_idx_o  = idx_q;
    assign match_cnt_o  = cnt_q;
    assign hit_total_o  = hit_q;

endmodule

// File: tb/tb_isi_match_pipe.sv
// Testbench for isi_match_pipe with N_CH=4 and a 2-bit hit statistic, so that
// saturation is easy to reach. The reference model keeps a queue of in-flight
// results: each result appears 2 cycles after acceptance, results leave
// head-first on a handshake, and the outputs hold when no result is present.
module tb_isi_match_pipe;

    localparam int BIT_ISI = 8;
    localparam int N_CH    = 4;
    localparam int BIT_TOL = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 3;
    localparam int STAT_W  = 2;
    localparam int HIT_MAX = (1 << STAT_W) - 1;

    logic                    clk, clr_n;
    logic                    in_valid, in_ready;
    logic [BIT_ISI-1:0]      isi_x;
    logic                    comp_addr_x;
    logic [N_CH*BIT_ISI-1:0] isi_y;
    logic [N_CH-1:0]         comp_addr_y;
    logic [BIT_TOL-1:0]      tol;
    logic                    tol_en, clear_stats;
    logic                    out_valid, out_ready;
    logic [BIT_ISI-1:0]      isi_z;
    logic                    match;
    logic [N_CH-1:0]         mask;
    logic [IDX_W-1:0]        idx;
    logic [CNT_W-1:0]        cnt;
    logic [STAT_W-1:0]       hit;

    isi_match_pipe #(
        .BIT_ISI(BIT_ISI), .N_CH(N_CH), .BIT_TOL(BIT_TOL),
        .IDX_W(IDX_W), .CNT_W(CNT_W), .STAT_W(STAT_W)
    ) dut (
        .clk_i(clk), .clr_n_i(clr_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .isi_x_i(isi_x), .comp_addr_x_i(comp_addr_x),
        .isi_y_i(isi_y), .comp_addr_y_i(comp_addr_y),
        .tol_i(tol), .tol_en_i(tol_en), .clear_stats_i(clear_stats),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .isi_z_o(isi_z), .match_o(match), .match_mask_o(mask),
        .match_idx_o(idx), .match_cnt_o(cnt), .hit_total_o(hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit done     = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    typedef struct {
        int x;
        int mask;
        int idx;
        int cnt;
        int m;
        int acc;
    } res_t;

    // Expected result of one beat, computed directly from the matching rules.
    function automatic res_t calc(input int x, input bit cax,
                                  input logic [N_CH*BIT_ISI-1:0] y,
                                  input logic [N_CH-1:0] cay,
                                  input int t, input bit ten);
        res_t r;
        r.x = x; r.mask = 0; r.idx = 0; r.cnt = 0; r.m = 0; r.acc = 0;
        for (int i = 0; i < N_CH; i++) begin
            int yi, d, thr;
            yi  = int'(y[i*BIT_ISI +: BIT_ISI]);
            d   = (x > yi) ? x - yi : yi - x;
            thr = ten ? t : 0;
            if (d <= thr && !cax && !cay[i] && x != 0) begin
                if (r.cnt == 0) r.idx = i;
                r.mask = r.mask | (1 << i);
                r.cnt++;
            end
        end
        r.m = (r.cnt != 0) ? 1 : 0;
        return r;
    endfunction

    res_t q[$];
    res_t last;
    int   hit_exp = 0;
    int   cyc = 0;

    // Reference model, updated on each clock edge and cleared by reset.
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q.delete();
            hit_exp = 0;
            cyc = 0;
            last = '{default: 0};
        end else begin : upd
            bit vis, pop, acc;
            res_t r;
            vis = (q.size() > 0) && (cyc >= q[0].acc + 1);
            pop = vis && out_ready;
            acc = in_valid && !(q.size() == 2 && !out_ready);
            if (clear_stats) hit_exp = 0;
            else if (pop && q[0].m != 0 && hit_exp < HIT_MAX) hit_exp++;
            if (pop) void'(q.pop_front());
            cyc++;
            if (acc) begin
                r = calc(int'(isi_x), comp_addr_x, isi_y, comp_addr_y, int'(tol), tol_en);
                r.acc = cyc;
                q.push_back(r);
            end
            if (q.size() > 0 && cyc >= q[0].acc + 1) last = q[0];
        end
    end

    // Compare process: checks every output on every falling edge.
    always @(negedge clk) begin
        if (!done) begin : cmp
            bit vis_e, rdy_e;
            vis_e = (q.size() > 0) && (cyc >= q[0].acc + 1);
            rdy_e = !(q.size() == 2 && !out_ready);
            chk("out_valid", out_valid, vis_e);
            chk("in_ready", in_ready, rdy_e);
            chk("isi_z", isi_z, last.x);
            chk("match", match, last.m);
            chk("match_mask", mask, last.mask);
            chk("match_idx", idx, last.idx);
            chk("match_cnt", cnt, last.cnt);
            chk("hit_total", hit, hit_exp);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one beat and holds it until it is accepted. Call at posedge+1.
    task automatic send(input logic [7:0] x, input bit cax, input logic [31:0] y,
                        input logic [3:0] cay, input logic [3:0] t, input bit ten);
        bit ok;
        ok = 0;
        in_valid = 1; isi_x = x; comp_addr_x = cax; isi_y = y;
        comp_addr_y = cay; tol = t; tol_en = ten;
        for (int k = 0; k < 64 && !ok; k++) begin
            #2 ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 0;
    endtask

    localparam logic [31:0] Y_EXACT = {8'h24, 8'h25, 8'h10, 8'h25};
    localparam logic [31:0] Y_TOL   = {8'h05, 8'h00, 8'h04, 8'hFF};

    initial begin : wdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        res_t r;
        clr_n = 0; in_valid = 0; isi_x = 0; comp_addr_x = 0; isi_y = 0;
        comp_addr_y = 0; tol = 0; tol_en = 0; clear_stats = 0; out_ready = 1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_hit_total", hit, 0);
        chk("rst_mask", mask, 0);
        idle(2);
        clr_n = 1;
        idle(1);
        chk("post_rst_in_ready", in_ready, 1);

        // Hand-computed values that pin the reference model.
        r = calc(8'h25, 0, Y_EXACT, 4'b0000, 0, 0);
        chk("pin_exact_mask", r.mask, 4'b0101);
        chk("pin_exact_idx", r.idx, 0);
        chk("pin_exact_cnt", r.cnt, 2);
        r = calc(8'h02, 0, Y_TOL, 4'b0000, 2, 1);
        chk("pin_tol_mask", r.mask, 4'b0110);
        chk("pin_tol_idx", r.idx, 1);
        r = calc(8'h02, 0, Y_TOL, 4'b0010, 2, 1);
        chk("pin_gate_y_mask", r.mask, 4'b0100);
        r = calc(8'h02, 1, Y_TOL, 4'b0000, 2, 1);
        chk("pin_gate_x_mask", r.mask, 0);
        r = calc(8'h00, 0, 32'h0, 4'b0000, 2, 1);
        chk("pin_zero_mask", r.mask, 0);

        // Exact-mode beat: the result appears 2 edges after acceptance.
        send(8'h25, 0, Y_EXACT, 4'b0000, 4'd0, 0);
        idle(1);
        chk("lit_exact_valid", out_valid, 1);
        chk("lit_exact_mask", mask, 4'b0101);
        chk("lit_exact_idx", idx, 0);
        chk("lit_exact_cnt", cnt, 2);
        chk("lit_exact_isi_z", isi_z, 8'h25);
        idle(1);
        chk("lit_exact_hit", hit, 1);

        // Tolerance beat, then the gating beats, sent back to back.
        send(8'h02, 0, Y_TOL, 4'b0000, 4'd2, 1);
        send(8'h02, 0, Y_TOL, 4'b0010, 4'd2, 1);
        send(8'h02, 1, Y_TOL, 4'b0000, 4'd2, 1);
        send(8'h00, 0, 32'h0, 4'b0000, 4'd2, 1);
        idle(1);
        chk("lit_zero_isi_z", isi_z, 8'h00);
        chk("lit_zero_mask", mask, 0);
        idle(2);

        // Saturation of the statistic, then clear together with a hit.
        clear_stats = 1; idle(1); clear_stats = 0;
        for (int k = 0; k < 5; k++) begin
            send(8'h25, 0, Y_EXACT, 4'b0000, 4'd0, 0);
            idle(2);
            chk($sformatf("lit_sat_hit%0d", k), hit, (k < 2) ? k + 1 : 3);
        end
        send(8'h25, 0, Y_EXACT, 4'b0000, 4'd0, 0);
        idle(1);
        clear_stats = 1;
        idle(1);
        clear_stats = 0;
        chk("lit_clear_wins", hit, 0);

        // Backpressure: 5 beats streamed while out_ready is low for 4 cycles.
        fork
            begin
                for (int k = 0; k < 5; k++)
                    send(8'(8'h30 + k), 0, {4{8'(8'h30 + k)}}, 4'b0000, 4'd0, 0);
            end
            begin
                idle(2);
                out_ready = 0;
                idle(2);
                chk("lit_stall_in_ready", in_ready, 0);
                idle(2);
                out_ready = 1;
            end
        join
        idle(4);

        // Reset while 2 beats are in flight.
        send(8'h25, 0, Y_EXACT, 4'b0000, 4'd0, 0);
        send(8'h26, 0, {4{8'h26}}, 4'b0000, 4'd0, 0);
        clr_n = 0;
        #1;
        chk("lit_rst_out_valid", out_valid, 0);
        chk("lit_rst_hit", hit, 0);
        idle(1);
        clr_n = 1;
        idle(1);
        chk("lit_rst_in_ready", in_ready, 1);
        idle(3);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            isi_x       = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, 1) == 1)
                    isi_y[i*8 +: 8] = isi_x + 8'($urandom_range(0, 6)) - 8'd3;
                else
                    isi_y[i*8 +: 8] = 8'($urandom);
            end
            comp_addr_x = ($urandom_range(0, 9) == 0);
            comp_addr_y = 4'($urandom) & 4'($urandom) & 4'($urandom);
            tol         = 4'($urandom);
            tol_en      = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 9) < 7);
            clear_stats = ($urandom_range(0, 29) == 0);
            idle(1);
        end
        in_valid = 0; out_ready = 1; clear_stats = 0;
        idle(4);

        done = 1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
